// File: rtl/ahb_decode_ctrl.sv
// AHB-lite address decoder, data-phase mux select register and default (ERROR) slave.
// Optional: define DECODE_ERR_CNT_EN to add the saturating err_count output.
module ahb_decode_ctrl #(
    parameter int unsigned          REGION_W    = 4,
    parameter logic [REGION_W-1:0]  SLV1_REGION = REGION_W'(0),
    parameter logic [REGION_W-1:0]  SLV2_REGION = REGION_W'(1),
    parameter logic [REGION_W-1:0]  SLV3_REGION = REGION_W'(2)
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hready,
    output logic        hsel_1,
    output logic        hsel_2,
    output logic        hsel_3,
    output logic [2:0]  sel,
    output logic        hreadyout_def,
    output logic        hresp_def
`ifdef DECODE_ERR_CNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

    localparam logic [2:0] SEL_SLV1 = 3'b000;
    localparam logic [2:0] SEL_SLV2 = 3'b001;
    localparam logic [2:0] SEL_SLV3 = 3'b010;
    localparam logic [2:0] SEL_DEF  = 3'b111;

    logic [REGION_W-1:0] w_region;
    logic                w_hit1;
    logic                w_hit2;
    logic                w_hit3;
    logic                w_unmapped;
    logic [2:0]          w_sel_next;
    logic                w_err_start;
    logic                w_unused_addr;

    ds_state_t           r_state;
    ds_state_t           w_state_next;
    logic [2:0]          r_sel;

    assign w_region      = haddr[31 -: REGION_W];
    assign w_unused_addr = ^haddr[31-REGION_W:0];

    // Priority only matters for illegal overlapping region parameters.
    assign w_hit1     = (w_region == SLV1_REGION);
    assign w_hit2     = (w_region == SLV2_REGION) && !w_hit1;
    assign w_hit3     = (w_region == SLV3_REGION) && !w_hit1 && !w_hit2;
    assign w_unmapped = !(w_hit1 || w_hit2 || w_hit3);

    assign hsel_1 = w_hit1;
    assign hsel_2 = w_hit2;
    assign hsel_3 = w_hit3;

    always_comb begin
        w_sel_next = SEL_DEF;
        if (w_hit1) begin
            w_sel_next = SEL_SLV1;
        end else if (w_hit2) begin
            w_sel_next = SEL_SLV2;
        end else if (w_hit3) begin
            w_sel_next = SEL_SLV3;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_sel <= SEL_DEF;
        end else if (hready) begin
            r_sel <= w_sel_next;
        end
    end

    assign sel = r_sel;

    // Only active (NONSEQ/SEQ) transfers to unmapped space earn an ERROR.
    assign w_err_start = hready && htrans[1] && w_unmapped;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state <= DS_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DS_IDLE: w_state_next = w_err_start ? DS_ERR1 : DS_IDLE;
            DS_ERR1: w_state_next = DS_ERR2;
            DS_ERR2: w_state_next = w_err_start ? DS_ERR1 : DS_IDLE;
            default: w_state_next = DS_IDLE;
        endcase
    end

    always_comb begin
        hreadyout_def = 1'b1;
        hresp_def     = 1'b0;
        case (r_state)
            DS_ERR1: begin
                hreadyout_def = 1'b0;
                hresp_def     = 1'b1;
            end
            DS_ERR2: begin
                hreadyout_def = 1'b1;
                hresp_def     = 1'b1;
            end
            default: begin
                hreadyout_def = 1'b1;
                hresp_def     = 1'b0;
            end
        endcase
    end

`ifdef DECODE_ERR_CNT_EN
    logic [15:0] r_err_count;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_err_count <= 16'd0;
        end else if ((w_state_next == DS_ERR1) && (r_state != DS_ERR1)
                     && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule
